processor_sequencer: RTL and testbench

//  Self-timed control unit for the shared-bus processor datapath (register file, A/G ALU latches, external data port).

---
 rtl/processor_pkg.sv | 35 +++
 rtl/processor_decode.sv | 46 ++++
 rtl/processor_sequencer.sv | 173 +++++++++++++++++
 tb/tb_processor_sequencer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/processor_pkg.sv
// Shared types and constants for the processor sequencer and its instruction decoder.
package processor_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_T0,
    S_T1,
    S_T2,
    S_T3
  } state_t;

  typedef enum logic [2:0] {
    C_LOAD,
    C_COPY,
    C_ALU,
    C_IMM_ADD,
    C_IMM_SUB,
    C_ILLEGAL
  } iclass_t;

  localparam logic [1:0] M_REG  = 2'b00;
  localparam logic [1:0] M_ADDI = 2'b01;
  localparam logic [1:0] M_SUBI = 2'b11;

  localparam logic [3:0] OP_LOAD = 4'd0;
  localparam logic [3:0] OP_COPY = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;

  // Register address width; a single-entry register file still needs one address bit.
  function automatic int ra_width(input int nreg);
    return (nreg < 2) ? 1 : $clog2(nreg);
  endfunction

endpackage

// File: rtl/processor_decode.sv
// Combinational instruction decoder: splits the IR into its fields and classifies the instruction.
module processor_decode
  import processor_pkg::*;
#(
  parameter int DATA_W    = 10,
  parameter int RA_W      = 2,
  parameter int ALU_FIRST = 2,
  parameter int ALU_LAST  = 11,
  localparam int IMM_W    = DATA_W - RA_W - 2
) (
  input  logic [DATA_W-1:0] ir,
  output logic [RA_W-1:0]   rx,
  output logic [RA_W-1:0]   ry,
  output logic [3:0]        opc,
  output logic [IMM_W-1:0]  fi,
  output iclass_t           cls
);

  logic [1:0] mode;

  assign rx   = ir[DATA_W-1 -: RA_W];
  assign ry   = ir[DATA_W-RA_W-1 -: RA_W];
  assign opc  = ir[5:2];
  assign mode = ir[1:0];
  assign fi   = ir[DATA_W-RA_W-1:2];

  // Classify: LOAD/COPY take precedence over the ALU opcode window; anything else is illegal.
  always_comb begin
    cls = C_ILLEGAL;
    case (mode)
      M_REG: begin
        if (opc == OP_LOAD) begin
          cls = C_LOAD;
        end else if (opc == OP_COPY) begin
          cls = C_COPY;
        end else if ((opc >= 4'(ALU_FIRST)) && (opc <= 4'(ALU_LAST))) begin
          cls = C_ALU;
        end
      end
      M_ADDI:  cls = C_IMM_ADD;
      M_SUBI:  cls = C_IMM_SUB;
      default: cls = C_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/processor_sequencer.sv
// Self-timed control unit: fetches an instruction over the shared bus, then sequences
// LOAD, COPY, ALU and immediate-ALU steps with a run/done handshake.
module processor_sequencer
  import processor_pkg::*;
#(
  parameter int DATA_W    = 10,
  parameter int NREG      = 4,
  parameter int ALU_FIRST = 2,
  parameter int ALU_LAST  = 11,
  localparam int RA_W     = ra_width(NREG),
  localparam int IMM_W    = DATA_W - RA_W - 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              run,
  input  logic [DATA_W-1:0] ir,
  output logic [DATA_W-1:0] imm,
  output logic [RA_W-1:0]   rin,
  output logic [RA_W-1:0]   rout,
  output logic              enw,
  output logic              enr,
  output logic              ain,
  output logic              gin,
  output logic              gout,
  output logic [3:0]        alu_op,
  output logic              ext,
  output logic              ir_in,
  output logic              busy,
  output logic              done,
  output logic              illegal,
  output logic [1:0]        step
);

  state_t            state;
  state_t            state_n;
  logic [RA_W-1:0]   rx;
  logic [RA_W-1:0]   ry;
  logic [3:0]        opc;
  logic [IMM_W-1:0]  fi;
  iclass_t           cls;
  logic              last;

  processor_decode #(
    .DATA_W   (DATA_W),
    .RA_W     (RA_W),
    .ALU_FIRST(ALU_FIRST),
    .ALU_LAST (ALU_LAST)
  ) u_decode (
    .ir (ir),
    .rx (rx),
    .ry (ry),
    .opc(opc),
    .fi (fi),
    .cls(cls)
  );

  // State register; reset drops straight back to IDLE from any step.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state and bus-control decode; every output idles at 0 so only one bus driver is ever active.
  always_comb begin
    state_n = state;
    imm     = '0;
    rin     = '0;
    rout    = '0;
    enw     = 1'b0;
    enr     = 1'b0;
    ain     = 1'b0;
    gin     = 1'b0;
    gout    = 1'b0;
    alu_op  = '0;
    ext     = 1'b0;
    ir_in   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    illegal = 1'b0;
    step    = 2'd0;
    last    = 1'b0;

    case (state)
      S_IDLE: begin
        if (run) state_n = S_T0;
      end

      S_T0: begin
        busy    = 1'b1;
        ext     = 1'b1;
        ir_in   = 1'b1;
        state_n = S_T1;
      end

      S_T1: begin
        busy = 1'b1;
        step = 2'd1;
        case (cls)
          C_LOAD: begin
            ext  = 1'b1;
            enw  = 1'b1;
            rin  = rx;
            last = 1'b1;
          end
          C_COPY: begin
            enr  = 1'b1;
            rout = ry;
            enw  = 1'b1;
            rin  = rx;
            last = 1'b1;
          end
          C_ALU: begin
            enr     = 1'b1;
            ain     = 1'b1;
            rout    = ry;
            state_n = S_T2;
          end
          C_IMM_ADD: begin
            imm     = {{(DATA_W-IMM_W){1'b0}}, fi};
            ain     = 1'b1;
            state_n = S_T2;
          end
          C_IMM_SUB: begin
            imm     = {{(DATA_W-IMM_W){1'b1}}, fi};
            ain     = 1'b1;
            state_n = S_T2;
          end
          default: begin
            illegal = 1'b1;
            state_n = run ? S_T0 : S_IDLE;
          end
        endcase
      end

      S_T2: begin
        busy    = 1'b1;
        step    = 2'd2;
        enr     = 1'b1;
        gin     = 1'b1;
        rout    = rx;
        state_n = S_T3;
      end

      S_T3: begin
        busy = 1'b1;
        step = 2'd3;
        enw  = 1'b1;
        rin  = rx;
        last = 1'b1;
        case (cls)
          C_ALU: begin
            alu_op = opc;
            gout   = 1'b1;
          end
          C_IMM_SUB: alu_op = OP_SUB;
          default:   alu_op = OP_ADD;
        endcase
      end

      default: state_n = S_IDLE;
    endcase

    // Final step of a legal instruction: report done and chain straight into the next fetch if run is held.
    if (last) begin
      done    = 1'b1;
      state_n = run ? S_T0 : S_IDLE;
    end
  end

endmodule

// File: tb/tb_processor_sequencer.sv
// Directed scoreboard bench for processor_sequencer: stimulus pushes hand-computed expected
// outputs per cycle, an independent monitor pops and compares them.
module tb_processor_sequencer;

  logic       clk;
  logic       resetn;
  logic       run;
  logic [9:0] ir;
  logic [9:0] imm;
  logic [1:0] rin, rout;
  logic       enw, enr, ain, gin, gout;
  logic [3:0] alu_op;
  logic       ext, ir_in, busy, done, illegal;
  logic [1:0] step;

  typedef struct packed {
    logic [1:0] step;
    logic       busy, done, illegal, ext, ir_in, enw, enr, ain, gin, gout;
    logic [1:0] rin, rout;
    logic [3:0] alu_op;
    logic [9:0] imm;
  } out_t;

  typedef struct {
    out_t  e;
    string nm;
  } exp_t;

  exp_t sb[$];
  int   errs   = 0;
  int   checks = 0;
  event smp;

  processor_sequencer dut (
    .clk    (clk),
    .resetn (resetn),
    .run    (run),
    .ir     (ir),
    .imm    (imm),
    .rin    (rin),
    .rout   (rout),
    .enw    (enw),
    .enr    (enr),
    .ain    (ain),
    .gin    (gin),
    .gout   (gout),
    .alu_op (alu_op),
    .ext    (ext),
    .ir_in  (ir_in),
    .busy   (busy),
    .done   (done),
    .illegal(illegal),
    .step   (step)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected-vector builder, argument order matches out_t.
  function automatic out_t o(input logic [1:0] st, input logic bz, dn, il, ex, ii, ew, er, ai, gi, go,
                             input logic [1:0] ri, ro, input logic [3:0] op, input logic [9:0] im);
    return {st, bz, dn, il, ex, ii, ew, er, ai, gi, go, ri, ro, op, im};
  endfunction

  // One clock cycle of stimulus: drive inputs after the edge and queue what this cycle must show.
  task automatic cyc(input logic r, input logic [9:0] i, input out_t e, input string nm);
    exp_t x;
    @(posedge clk);
    #1;
    run  = r;
    ir   = i;
    x.e  = e;
    x.nm = nm;
    sb.push_back(x);
  endtask

  // Monitor: compare on the falling edge, or on demand between edges.
  initial begin
    forever begin
      @(negedge clk or smp);
      if (sb.size() > 0) begin
        exp_t x;
        out_t g;
        x = sb.pop_front();
        g = {step, busy, done, illegal, ext, ir_in, enw, enr, ain, gin, gout, rin, rout, alu_op, imm};
        checks++;
        if (g !== x.e) begin
          errs++;
          $display("FAIL %s: got=%h expected=%h", x.nm, g, x.e);
        end
      end
    end
  end

  localparam logic [9:0] IR_LOAD = 10'b10_00_0000_00;  // Rx=2
  localparam logic [9:0] IR_ALU5 = 10'b01_11_0101_00;  // Rx=1 Ry=3 opc=5
  localparam logic [9:0] IR_SUBI = 10'b11_101010_11;   // Rx=3 FI=6'h2A
  localparam logic [9:0] IR_ADDI = 10'b11_101010_01;
  localparam logic [9:0] IR_COPY = 10'b01_10_0001_00;  // Rx=1 Ry=2
  localparam logic [9:0] IR_M10  = 10'b00_00_0000_10;
  localparam logic [9:0] IR_OPF  = 10'b00_00_1111_00;

  out_t ID, T0, LD1, AL1, AL2, AL3, SB1, SB2, SB3, AD1, AD3, CP1, IL1;

  initial begin
    ID  = '0;
    T0  = o(0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 10'h000);
    LD1 = o(1, 1, 1, 0, 1, 0, 1, 0, 0, 0, 0, 2, 0, 0, 10'h000);
    AL1 = o(1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 3, 0, 10'h000);
    AL2 = o(2, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1, 0, 10'h000);
    AL3 = o(3, 1, 1, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0, 5, 10'h000);
    SB1 = o(1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 10'h3EA);
    SB2 = o(2, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 3, 0, 10'h000);
    SB3 = o(3, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 3, 0, 3, 10'h000);
    AD1 = o(1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 10'h02A);
    AD3 = o(3, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 3, 0, 2, 10'h000);
    CP1 = o(1, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 1, 2, 0, 10'h000);
    IL1 = o(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 10'h000);

    resetn = 1'b0;
    run    = 1'b0;
    ir     = '0;

    // Reset holds IDLE even with run requested across an edge.
    cyc(1, IR_LOAD, ID, "rst_idle0");
    cyc(1, IR_LOAD, ID, "rst_idle1");
    cyc(0, IR_LOAD, ID, "rst_idle2");
    resetn = 1'b1;

    // LOAD, run for two cycles then dropped.
    cyc(1, IR_LOAD, ID,  "load_idle");
    cyc(1, IR_LOAD, T0,  "load_t0");
    cyc(0, IR_LOAD, LD1, "load_t1");
    cyc(0, IR_LOAD, ID,  "load_back_idle");

    // ALU opcode 5; run dropped after the request, instruction still completes.
    cyc(1, IR_ALU5, ID,  "alu_idle");
    cyc(0, IR_ALU5, T0,  "alu_t0");
    cyc(0, IR_ALU5, AL1, "alu_t1");
    cyc(0, IR_ALU5, AL2, "alu_t2");
    cyc(0, IR_ALU5, AL3, "alu_t3");
    cyc(0, IR_ALU5, ID,  "alu_back_idle");

    // SUBI then ADDI with the same immediate field.
    cyc(1, IR_SUBI, ID,  "subi_idle");
    cyc(0, IR_SUBI, T0,  "subi_t0");
    cyc(0, IR_SUBI, SB1, "subi_t1");
    cyc(0, IR_SUBI, SB2, "subi_t2");
    cyc(0, IR_SUBI, SB3, "subi_t3");
    cyc(1, IR_ADDI, ID,  "addi_idle");
    cyc(0, IR_ADDI, T0,  "addi_t0");
    cyc(0, IR_ADDI, AD1, "addi_t1");
    cyc(0, IR_ADDI, SB2, "addi_t2");
    cyc(0, IR_ADDI, AD3, "addi_t3");
    cyc(0, IR_ADDI, ID,  "addi_back_idle");

    // COPY then LOAD back to back with run held high.
    cyc(1, IR_COPY, ID,  "b2b_idle");
    cyc(1, IR_COPY, T0,  "b2b_copy_t0");
    cyc(1, IR_COPY, CP1, "b2b_copy_t1");
    cyc(1, IR_LOAD, T0,  "b2b_load_t0");
    cyc(0, IR_LOAD, LD1, "b2b_load_t1");
    cyc(0, IR_LOAD, ID,  "b2b_back_idle");

    // Illegal encodings: mode 10, then opcode 15 with run held so it refetches.
    cyc(1, IR_M10, ID,   "ill_m10_idle");
    cyc(0, IR_M10, T0,   "ill_m10_t0");
    cyc(0, IR_M10, IL1,  "ill_m10_t1");
    cyc(1, IR_OPF, ID,   "ill_opf_idle");
    cyc(1, IR_OPF, T0,   "ill_opf_t0");
    cyc(1, IR_OPF, IL1,  "ill_opf_t1");
    cyc(0, IR_LOAD, T0,  "ill_refetch_t0");
    cyc(0, IR_LOAD, LD1, "ill_refetch_t1");
    cyc(0, IR_LOAD, ID,  "ill_back_idle");

    // Asynchronous reset pulse during ALU T2.
    cyc(1, IR_ALU5, ID,  "rst_alu_idle");
    cyc(0, IR_ALU5, T0,  "rst_alu_t0");
    cyc(0, IR_ALU5, AL1, "rst_alu_t1");
    cyc(0, IR_ALU5, AL2, "rst_alu_t2");
    @(negedge clk);
    #1;
    resetn = 1'b0;
    #1;
    resetn = 1'b1;
    begin
      exp_t x;
      x.e  = ID;
      x.nm = "rst_async_no_edge";
      sb.push_back(x);
      ->smp;
    end
    cyc(0, IR_ALU5, ID,  "rst_hold_idle0");
    cyc(0, IR_ALU5, ID,  "rst_hold_idle1");
    cyc(1, IR_ALU5, ID,  "rst_rerun_idle");
    cyc(0, IR_ALU5, T0,  "rst_rerun_t0");
    cyc(0, IR_ALU5, AL1, "rst_rerun_t1");
    cyc(0, IR_ALU5, AL2, "rst_rerun_t2");
    cyc(0, IR_ALU5, AL3, "rst_rerun_t3");
    cyc(0, IR_ALU5, ID,  "rst_rerun_idle_end");

    // Drain the scoreboard within a bounded number of cycles.
    for (int k = 0; k < 5 && sb.size() > 0; k++) @(posedge clk);
    if (sb.size() > 0) begin
      errs++;
      checks++;
      $display("FAIL drain: pending=%0d expected=0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
